supply_arbiter_2x1: RTL and testbench

Time-shares the single irrigation supply line between two requesters, A and B (e.g. sprinkler and drip zones). It drives the selector of the 2:1 source/zone multiplexer in the irrigation datapath, where selector=1 routes input a and selector=0 routes input b. Grants are issued round-robin, with a maximum grant length and a break-before-make dead time between owners. Time is counted in `tick` pulses from the system timebase.

---
 rtl/supply_arbiter_2x1_if.sv | 23 ++
 rtl/supply_arbiter_2x1.sv | 112 +++++++++++
 tb/tb_supply_arbiter_2x1.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/supply_arbiter_2x1_if.sv
// Request/grant bundle between the irrigation requesters and the supply arbiter.
interface supply_arbiter_2x1_if;
    logic tick;
    logic req_a;
    logic req_b;
    logic grant_a;
    logic grant_b;
    logic selector;
    logic supply_enable;
    logic switching;

    // Requester / timebase side: drives requests and tick, observes grants.
    modport master (
        output tick, req_a, req_b,
        input  grant_a, grant_b, selector, supply_enable, switching
    );

    // Arbiter side.
    modport slave (
        input  tick, req_a, req_b,
        output grant_a, grant_b, selector, supply_enable, switching
    );
endinterface

// File: rtl/supply_arbiter_2x1.sv
// Round-robin arbiter for the shared irrigation supply line. Grants have a
// maximum length (pre-empted only when the other side waits), and every change
// of owner passes through a break-before-make dead time.
module supply_arbiter_2x1 #(
    parameter int unsigned MAX_GRANT_TICKS = 4,
    parameter int unsigned DEAD_TICKS      = 2,
    parameter int unsigned COUNT_WIDTH     = 4
) (
    input logic                  clock,
    input logic                  reset,
    supply_arbiter_2x1_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StGrantA, StGrantB, StDead} state_e;

    localparam logic [COUNT_WIDTH-1:0] MaxCount  = COUNT_WIDTH'(MAX_GRANT_TICKS);
    localparam logic [COUNT_WIDTH-1:0] DeadCount = COUNT_WIDTH'(DEAD_TICKS);
    localparam logic [COUNT_WIDTH-1:0] CountOne  = COUNT_WIDTH'(1);

    state_e                  state_q, state_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic                    last_a_q, last_a_d;   // 1: A owned last, 0: B owned last
    logic                    grant_a_q, grant_a_d;
    logic                    grant_b_q, grant_b_d;
    logic                    selector_q, selector_d;
    logic                    switching_q, switching_d;
    logic                    own_req, other_req;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        last_a_d    = last_a_q;
        grant_a_d   = grant_a_q;
        grant_b_d   = grant_b_q;
        selector_d  = selector_q;
        switching_d = switching_q;
        own_req     = (state_q == StGrantA) ? bus.req_a : bus.req_b;
        other_req   = (state_q == StGrantA) ? bus.req_b : bus.req_a;

        unique case (state_q)
            StIdle: begin
                // On a tie, the side that did not own the supply last wins.
                if (bus.req_a && (!bus.req_b || !last_a_q)) begin
                    state_d    = StGrantA;
                    grant_a_d  = 1'b1;
                    selector_d = 1'b1;
                    last_a_d   = 1'b1;
                    count_d    = '0;
                end else if (bus.req_b) begin
                    state_d    = StGrantB;
                    grant_b_d  = 1'b1;
                    selector_d = 1'b0;
                    last_a_d   = 1'b0;
                    count_d    = '0;
                end
            end
            StGrantA, StGrantB: begin
                if (!own_req || (count_q == MaxCount && other_req)) begin
                    state_d     = StDead;
                    grant_a_d   = 1'b0;
                    grant_b_d   = 1'b0;
                    switching_d = 1'b1;
                    count_d     = '0;
                end else if (bus.tick && count_q < MaxCount) begin
                    count_d = count_q + CountOne;
                end
            end
            StDead: begin
                // Requests are ignored here; only the dead-time count matters.
                if (count_q == DeadCount) begin
                    state_d     = StIdle;
                    switching_d = 1'b0;
                    count_d     = '0;
                end else if (bus.tick) begin
                    count_d = count_q + CountOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            last_a_q    <= 1'b0;
            grant_a_q   <= 1'b0;
            grant_b_q   <= 1'b0;
            selector_q  <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            last_a_q    <= last_a_d;
            grant_a_q   <= grant_a_d;
            grant_b_q   <= grant_b_d;
            selector_q  <= selector_d;
            switching_q <= switching_d;
        end
    end

    assign bus.grant_a       = grant_a_q;
    assign bus.grant_b       = grant_b_q;
    assign bus.selector      = selector_q;
    assign bus.switching     = switching_q;
    assign bus.supply_enable = grant_a_q | grant_b_q;

endmodule

// File: tb/tb_supply_arbiter_2x1.sv
// Bench for supply_arbiter_2x1: directed scenarios followed by random requests,
// all checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_supply_arbiter_2x1;

    localparam int MaxTicks  = 4;
    localparam int DeadTicks = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    supply_arbiter_2x1_if bus ();

    supply_arbiter_2x1 #(
        .MAX_GRANT_TICKS (MaxTicks),
        .DEAD_TICKS      (DeadTicks),
        .COUNT_WIDTH     (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    // Model: who holds the supply (0 none, 1 A, 2 B), whether the line is in
    // its dead gap, ticks elapsed in the current grant/gap, the last owner.
    int m_owner;
    bit m_gap;
    int m_elapsed;
    int m_last;
    bit m_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = 0;
        m_gap     = 1'b0;
        m_elapsed = 0;
        m_last    = 2;
        m_sel     = 1'b0;
    endtask

    task automatic model_edge(input bit ra, input bit rb, input bit tk);
        bit own, other;
        if (m_gap) begin
            if (m_elapsed == DeadTicks) m_gap = 1'b0;
            else if (tk) m_elapsed++;
        end else if (m_owner == 0) begin
            if (ra && (!rb || m_last == 2)) begin
                m_owner = 1; m_last = 1; m_sel = 1'b1; m_elapsed = 0;
            end else if (rb) begin
                m_owner = 2; m_last = 2; m_sel = 1'b0; m_elapsed = 0;
            end
        end else begin
            own   = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!own || (m_elapsed >= MaxTicks && other)) begin
                m_owner = 0; m_gap = 1'b1; m_elapsed = 0;
            end else if (tk && m_elapsed < MaxTicks) begin
                m_elapsed++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("grant_a", 32'(bus.grant_a), 32'(m_owner == 1));
        chk("grant_b", 32'(bus.grant_b), 32'(m_owner == 2));
        chk("selector", 32'(bus.selector), 32'(m_sel));
        chk("switching", 32'(bus.switching), 32'(m_gap));
        chk("supply_enable", 32'(bus.supply_enable), 32'(m_owner != 0));
        chk("never_both", 32'(bus.grant_a & bus.grant_b), 32'(0));
    endtask

    // Drive one clock of inputs, then check just after the rising edge.
    task automatic cycle(input bit ra, input bit rb, input bit tk);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.tick  = tk;
        @(posedge clock);
        model_edge(ra, rb, tk);
        #1;
        check_outputs();
    endtask

    // Pulse reset between edges and confirm outputs clear before the next edge.
    task automatic reset_mid_cycle();
        #2 reset = 1'b1;
        #1;
        chk("rst_grant_a", 32'(bus.grant_a), 32'(0));
        chk("rst_grant_b", 32'(bus.grant_b), 32'(0));
        chk("rst_selector", 32'(bus.selector), 32'(0));
        chk("rst_supply_enable", 32'(bus.supply_enable), 32'(0));
        chk("rst_switching", 32'(bus.switching), 32'(0));
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        int run_a, run_dead, run_idle;
        bit ra, rb;

        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.tick  = 1'b0;
        model_reset();

        // Power-on reset.
        #1 reset = 1'b1;
        #1;
        check_outputs();
        @(posedge clock);
        #1 reset = 1'b0;

        // Single request A, dropped after four edges.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1);
        chk("single_a_granted", 32'(bus.grant_a), 32'(1));
        cycle(1'b0, 1'b0, 1'b1);
        chk("single_a_dead", 32'(bus.switching), 32'(1));
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

        // Reset mid-grant, then idle with no requests.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        reset_mid_cycle();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);

        // Tie after reset: A first, then B after the gap.
        reset_mid_cycle();
        cycle(1'b1, 1'b1, 1'b1);
        chk("tie_a_first", 32'(bus.grant_a), 32'(1));
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("tie_then_b", 32'(bus.grant_b), 32'(1));
        chk("tie_b_selector", 32'(bus.selector), 32'(0));

        // Continuous contention: measure grant, dead and idle run lengths.
        reset_mid_cycle();
        run_a = 0; run_dead = 0; run_idle = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 1'b1);
            if (bus.grant_a) run_a++;
            else if (run_a > 0) begin
                chk("preempt_grant_len", 32'(run_a), 32'(MaxTicks + 1));
                run_a = 0;
            end
            if (bus.switching) run_dead++;
            else if (run_dead > 0) begin
                chk("dead_len", 32'(run_dead), 32'(DeadTicks + 1));
                run_dead = 0;
            end
            if (!bus.switching && !bus.supply_enable) run_idle++;
            else if (run_idle > 0) begin
                chk("idle_len", 32'(run_idle), 32'(1));
                run_idle = 0;
            end
        end

        // Sole owner overrun, then a late request pre-empts at the next edge.
        reset_mid_cycle();
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("overrun_hold_b", 32'(bus.grant_b), 32'(1));
        cycle(1'b1, 1'b1, 1'b1);
        chk("late_preempt", 32'(bus.switching), 32'(1));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);

        // Stalled timebase holds the grant; resumed ticks complete the count.
        reset_mid_cycle();
        cycle(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0);
        chk("stall_hold_a", 32'(bus.grant_a), 32'(1));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1);
        chk("resume_still_a", 32'(bus.grant_a), 32'(1));
        cycle(1'b1, 1'b1, 1'b1);
        chk("resume_preempt", 32'(bus.switching), 32'(1));
        cycle(1'b1, 1'b1, 1'b1);
        reset_mid_cycle();

        // Random requests and timebase.
        ra = 1'b0; rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) ra = ~ra;
            if ($urandom_range(0, 7) == 0) rb = ~rb;
            cycle(ra, rb, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) reset_mid_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
